// File: rtl/mode_ac_pkg.sv
// Shared state encoding and default widths for the multi-channel edge detector.
// Latency and backpressure: not applicable (definitions only).
package mode_ac_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_RCW    = 4;
    localparam int DEF_TCW    = 16;
    localparam int DEF_PWW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNTING = 3'd1,
        ST_HOLD     = 3'd2,
        ST_FALL     = 3'd3,
        ST_END      = 3'd4
    } state_t;

endpackage

// File: rtl/mode_ac_edge_channel.sv
// One detector channel: rise qualification, hold, hysteretic fall/timeout, end guard.
// Latency: pulses one cycle after the qualifying sample; backpressure: none, samples are strobed by data_valid.
module mode_ac_edge_channel
    import mode_ac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RCW   = DEF_RCW,
    parameter int TCW   = DEF_TCW,
    parameter int PWW   = DEF_PWW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] threshold,
    input  logic [RCW-1:0]   run_needed,
    input  logic [TCW-1:0]   hold_time,
    input  logic [TCW-1:0]   final_time,
    input  logic [TCW-1:0]   fall_timeout,
    input  logic [WIDTH-1:0] fall_margin,
    input  logic             ch_enable,
    input  logic             rearm,
    output logic             rise_edge,
    output logic             fall_edge,
    output logic             timeout,
    output logic             pw_valid,
    output logic             busy,
    output logic [PWW-1:0]   pulse_width
);

    state_t           state, state_nxt;
    logic [RCW-1:0]   run, run_nxt;
    logic [TCW-1:0]   timer, timer_nxt;
    logic [PWW-1:0]   pw_cnt, pw_cnt_nxt;
    logic [WIDTH-1:0] prev_val, prev_nxt;
    logic [WIDTH-1:0] fall_thr, fall_thr_nxt;
    logic [PWW-1:0]   pulse_width_nxt;
    logic             rise_nxt, fall_nxt, to_nxt, pwv_nxt;
    logic             do_rise;

    logic [PWW-1:0]   pw_inc;
    logic [RCW:0]     run_inc;

    assign pw_inc  = (&pw_cnt) ? pw_cnt : pw_cnt + PWW'(1);
    assign run_inc = {1'b0, run} + (RCW+1)'(1);
    assign busy    = (state == ST_HOLD) || (state == ST_FALL) || (state == ST_END);

    always_comb begin
        state_nxt       = state;
        run_nxt         = run;
        timer_nxt       = timer;
        pw_cnt_nxt      = pw_cnt;
        prev_nxt        = prev_val;
        fall_thr_nxt    = fall_thr;
        pulse_width_nxt = pulse_width;
        rise_nxt        = 1'b0;
        fall_nxt        = 1'b0;
        to_nxt          = 1'b0;
        pwv_nxt         = 1'b0;
        do_rise         = 1'b0;

        if (rearm || !ch_enable) begin
            state_nxt    = ST_IDLE;
            run_nxt      = '0;
            timer_nxt    = '0;
            pw_cnt_nxt   = '0;
            prev_nxt     = '0;
            fall_thr_nxt = '0;
        end else if (data_valid) begin
            prev_nxt = data_in;
            case (state)
                ST_IDLE: begin
                    if ((data_in >= threshold) && (data_in > prev_val)) begin
                        if (run_needed <= RCW'(1)) begin
                            do_rise = 1'b1;
                        end else begin
                            state_nxt = ST_COUNTING;
                            run_nxt   = RCW'(1);
                        end
                    end
                end
                ST_COUNTING: begin
                    // >= rather than == so a live drop of run_needed cannot strand the run
                    if (data_in > prev_val) begin
                        if (run_inc >= {1'b0, run_needed}) do_rise = 1'b1;
                        else                               run_nxt = run_inc[RCW-1:0];
                    end else begin
                        state_nxt = ST_IDLE;
                        run_nxt   = '0;
                    end
                end
                ST_HOLD: begin
                    pw_cnt_nxt = pw_inc;
                    if (timer == '0) begin
                        state_nxt = ST_FALL;
                        timer_nxt = fall_timeout;
                    end else begin
                        timer_nxt = timer - TCW'(1);
                    end
                end
                ST_FALL: begin
                    pw_cnt_nxt = pw_inc;
                    // timer parks at 0 when the timeout was disabled at load
                    if (data_in <= fall_thr) begin
                        fall_nxt        = 1'b1;
                        pwv_nxt         = 1'b1;
                        pulse_width_nxt = pw_inc;
                        timer_nxt       = final_time;
                        state_nxt       = ST_END;
                    end else if (timer == TCW'(1)) begin
                        to_nxt    = 1'b1;
                        timer_nxt = final_time;
                        state_nxt = ST_END;
                    end else if (timer != '0) begin
                        timer_nxt = timer - TCW'(1);
                    end
                end
                ST_END: begin
                    if (timer == '0) state_nxt = ST_IDLE;
                    else             timer_nxt = timer - TCW'(1);
                end
                default: begin
                    state_nxt = ST_IDLE;
                    run_nxt   = '0;
                    timer_nxt = '0;
                end
            endcase

            if (do_rise) begin
                rise_nxt     = 1'b1;
                fall_thr_nxt = (data_in >= fall_margin) ? data_in - fall_margin : '0;
                timer_nxt    = hold_time;
                pw_cnt_nxt   = '0;
                run_nxt      = '0;
                state_nxt    = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            run         <= '0;
            timer       <= '0;
            pw_cnt      <= '0;
            prev_val    <= '0;
            fall_thr    <= '0;
            pulse_width <= '0;
            rise_edge   <= 1'b0;
            fall_edge   <= 1'b0;
            timeout     <= 1'b0;
            pw_valid    <= 1'b0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            timer       <= timer_nxt;
            pw_cnt      <= pw_cnt_nxt;
            prev_val    <= prev_nxt;
            fall_thr    <= fall_thr_nxt;
            pulse_width <= pulse_width_nxt;
            rise_edge   <= rise_nxt;
            fall_edge   <= fall_nxt;
            timeout     <= to_nxt;
            pw_valid    <= pwv_nxt;
        end
    end

endmodule

// File: rtl/mode_ac_edge_detector_mc.sv
// NUM_CH independent edge-detector channels behind a shared reset synchroniser.
// Latency: pulses one cycle after the qualifying sample; backpressure: none.
module mode_ac_edge_detector_mc
    import mode_ac_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int RCW    = DEF_RCW,
    parameter int TCW    = DEF_TCW,
    parameter int PWW    = DEF_PWW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       data_valid,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH*WIDTH-1:0] threshold,
    input  logic [RCW-1:0]          run_needed,
    input  logic [TCW-1:0]          hold_time,
    input  logic [TCW-1:0]          final_time,
    input  logic [TCW-1:0]          fall_timeout,
    input  logic [WIDTH-1:0]        fall_margin,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       rearm,
    output logic [NUM_CH-1:0]       rise_edge,
    output logic [NUM_CH-1:0]       fall_edge,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       pw_valid,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*PWW-1:0]   pulse_width
);

    // assertion is immediate, release takes two clk edges
    logic [1:0] rst_sync;
    logic       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_core_n = rst_sync[1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mode_ac_edge_channel #(
            .WIDTH (WIDTH),
            .RCW   (RCW),
            .TCW   (TCW),
            .PWW   (PWW)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_core_n),
            .data_valid   (data_valid[k]),
            .data_in      (data_in[k*WIDTH +: WIDTH]),
            .threshold    (threshold[k*WIDTH +: WIDTH]),
            .run_needed   (run_needed),
            .hold_time    (hold_time),
            .final_time   (final_time),
            .fall_timeout (fall_timeout),
            .fall_margin  (fall_margin),
            .ch_enable    (ch_enable[k]),
            .rearm        (rearm[k]),
            .rise_edge    (rise_edge[k]),
            .fall_edge    (fall_edge[k]),
            .timeout      (timeout[k]),
            .pw_valid     (pw_valid[k]),
            .busy         (busy[k]),
            .pulse_width  (pulse_width[k*PWW +: PWW])
        );
    end

endmodule

// File: tb/tb_mode_ac_edge_detector_mc.sv
// Bench for mode_ac_edge_detector_mc: directed table, corner sequences, random run vs model.
module tb_mode_ac_edge_detector_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  data_valid, ch_enable, rearm;
    logic [63:0] data_in, threshold;
    logic [3:0]  run_needed;
    logic [15:0] hold_time, final_time, fall_timeout;
    logic [31:0] fall_margin;
    logic [1:0]  rise_edge, fall_edge, timeout, pw_valid, busy;
    logic [31:0] pulse_width;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mode_ac_edge_detector_mc dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
        .threshold(threshold), .run_needed(run_needed), .hold_time(hold_time),
        .final_time(final_time), .fall_timeout(fall_timeout), .fall_margin(fall_margin),
        .ch_enable(ch_enable), .rearm(rearm), .rise_edge(rise_edge), .fall_edge(fall_edge),
        .timeout(timeout), .pw_valid(pw_valid), .busy(busy), .pulse_width(pulse_width)
    );

    // Reference model: phase names plus "samples remaining" counters
    string  m_ph[2];
    longint m_streak[2], m_prev[2], m_fthr[2], m_left[2], m_fall_n[2], m_to[2], m_width[2];
    bit     e_rise[2], e_fall[2], e_to[2], e_pwv[2];
    longint e_pw[2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_ph[c] = "idle"; m_streak[c] = 0; m_prev[c] = 0; m_fthr[c] = 0;
            m_left[c] = 0; m_fall_n[c] = 0; m_to[c] = 0; m_width[c] = 0;
            e_rise[c] = 0; e_fall[c] = 0; e_to[c] = 0; e_pwv[c] = 0; e_pw[c] = 0;
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            longint d, thr, need;
            bit go;
            d   = longint'(data_in[c*32 +: 32]);
            thr = longint'(threshold[c*32 +: 32]);
            need = (run_needed < 2) ? 1 : longint'(run_needed);
            go = 0;
            e_rise[c] = 0; e_fall[c] = 0; e_to[c] = 0; e_pwv[c] = 0;
            if (!ch_enable[c] || rearm[c]) begin
                m_ph[c] = "idle"; m_streak[c] = 0; m_prev[c] = 0;
                m_fthr[c] = 0; m_width[c] = 0; m_left[c] = 0;
            end else if (data_valid[c]) begin
                if (m_ph[c] == "idle") begin
                    if (d >= thr && d > m_prev[c]) begin
                        m_streak[c] = 1;
                        if (m_streak[c] >= need) go = 1; else m_ph[c] = "count";
                    end
                end else if (m_ph[c] == "count") begin
                    if (d > m_prev[c]) begin
                        m_streak[c]++;
                        if (m_streak[c] >= need) go = 1;
                    end else begin
                        m_ph[c] = "idle"; m_streak[c] = 0;
                    end
                end else if (m_ph[c] == "hold") begin
                    if (m_width[c] < 65535) m_width[c]++;
                    if (m_left[c] == 1) begin
                        m_ph[c] = "fall"; m_fall_n[c] = 0; m_to[c] = fall_timeout;
                    end else m_left[c]--;
                end else if (m_ph[c] == "fall") begin
                    if (m_width[c] < 65535) m_width[c]++;
                    m_fall_n[c]++;
                    if (d <= m_fthr[c]) begin
                        e_fall[c] = 1; e_pwv[c] = 1; e_pw[c] = m_width[c];
                        m_left[c] = longint'(final_time) + 1; m_ph[c] = "end";
                    end else if (m_to[c] != 0 && m_fall_n[c] == m_to[c]) begin
                        e_to[c] = 1;
                        m_left[c] = longint'(final_time) + 1; m_ph[c] = "end";
                    end
                end else begin
                    m_left[c]--;
                    if (m_left[c] == 0) m_ph[c] = "idle";
                end
                if (go) begin
                    e_rise[c] = 1; m_streak[c] = 0; m_width[c] = 0; m_ph[c] = "hold";
                    m_fthr[c] = (d > longint'(fall_margin)) ? d - longint'(fall_margin) : 0;
                    m_left[c] = longint'(hold_time) + 1;
                end
                m_prev[c] = d;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            logic [20:0] act, exp;
            bit eb;
            eb  = (m_ph[c] == "hold") || (m_ph[c] == "fall") || (m_ph[c] == "end");
            act = {rise_edge[c], fall_edge[c], timeout[c], pw_valid[c], busy[c], pulse_width[c*16 +: 16]};
            exp = {e_rise[c], e_fall[c], e_to[c], e_pwv[c], eb, e_pw[c][15:0]};
            chk($sformatf("model ch%0d t=%0t", c, $time), longint'(act), longint'(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic s0(input int d, input bit er, input bit ef, input bit et, input bit eb, input string nm);
        data_in[31:0] = d;
        data_valid = 2'b01;
        step();
        chk(nm, longint'({rise_edge[0], fall_edge[0], timeout[0], busy[0]}), longint'({er, ef, et, eb}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset outputs", longint'({rise_edge, fall_edge, timeout, pw_valid, busy, pulse_width}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    typedef struct {
        int d;
        bit rise, fall, pwv, busy;
        int pw;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{50,  0, 0, 0, 0, 0};
        tbl[1]  = '{120, 0, 0, 0, 0, 0};
        tbl[2]  = '{130, 0, 0, 0, 0, 0};
        tbl[3]  = '{140, 1, 0, 0, 1, 0};
        tbl[4]  = '{150, 0, 0, 0, 1, 0};
        tbl[5]  = '{150, 0, 0, 0, 1, 0};
        tbl[6]  = '{150, 0, 0, 0, 1, 0};
        tbl[7]  = '{150, 0, 0, 0, 1, 0};
        tbl[8]  = '{121, 0, 0, 0, 1, 0};
        tbl[9]  = '{120, 0, 1, 1, 1, 6};
        tbl[10] = '{10,  0, 0, 0, 1, 6};
        tbl[11] = '{10,  0, 0, 0, 0, 6};

        rst_n = 1'b0;
        data_valid = 2'b00; ch_enable = 2'b11; rearm = 2'b00;
        data_in = '0; threshold = {32'd100, 32'd100};
        run_needed = 4'd3; hold_time = 16'd2; final_time = 16'd1;
        fall_timeout = 16'd0; fall_margin = 32'd20;
        model_reset();
        @(negedge clk);
        do_reset();

        // rise after a 3-sample run, hysteretic fall, pulse width 6
        for (int i = 0; i < 12; i++) begin
            data_in[31:0] = tbl[i].d;
            data_valid = 2'b01;
            step();
            chk($sformatf("table row %0d", i),
                longint'({rise_edge[0], fall_edge[0], pw_valid[0], busy[0], pulse_width[15:0]}),
                longint'({tbl[i].rise, tbl[i].fall, tbl[i].pwv, tbl[i].busy, tbl[i].pw[15:0]}));
        end

        // broken run restarts at 1 on 126, so 127,128 complete it
        fall_timeout = 16'd4;
        s0(120, 0, 0, 0, 0, "run 120");
        s0(130, 0, 0, 0, 0, "run 130");
        s0(125, 0, 0, 0, 0, "run break 125");
        s0(126, 0, 0, 0, 0, "run restart 126");
        s0(127, 0, 0, 0, 0, "run 127");
        s0(128, 1, 0, 0, 1, "rise on 128");
        // no fall at 200: timeout on the 4th FALL sample, then 2 END samples
        for (int i = 0; i < 6; i++) s0(200, 0, 0, 0, 1, $sformatf("hold/fall %0d", i));
        s0(200, 0, 0, 1, 1, "timeout 4th fall");
        s0(200, 0, 0, 0, 1, "end sample 1");
        s0(200, 0, 0, 0, 0, "idle after end");

        // rearm ch1 in FALL while ch0 sits in HOLD
        hold_time = 16'd0; fall_timeout = 16'd0; run_needed = 4'd1;
        data_in[63:32] = 150; data_valid = 2'b10;
        step();
        chk("ch1 rise", longint'(rise_edge[1]), 1);
        step();
        hold_time = 16'd5;
        data_in[31:0] = 250; data_valid = 2'b11;
        step();
        rearm = 2'b10;
        step();
        chk("rearm isolation busy", longint'(busy), 2'b01);
        rearm = 2'b00;
        data_in = '0; data_valid = 2'b01;
        repeat (10) step();

        // large margin saturates fall_thr to 0
        fall_margin = 32'd500; final_time = 16'd3; hold_time = 16'd0;
        rearm = 2'b01; data_valid = 2'b01;
        step();
        rearm = 2'b00;
        s0(140, 1, 0, 0, 1, "margin rise");
        s0(5,   0, 0, 0, 1, "margin hold");
        s0(5,   0, 0, 0, 1, "margin fall 5");
        s0(1,   0, 0, 0, 1, "margin fall 1");
        s0(0,   0, 1, 0, 1, "margin fall 0");
        chk("margin pw", longint'(pulse_width[15:0]), 4);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk("async reset", longint'({rise_edge, fall_edge, timeout, pw_valid, busy, pulse_width}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                run_needed   = 4'($urandom_range(0, 4));
                hold_time    = 16'($urandom_range(0, 3));
                final_time   = 16'($urandom_range(0, 3));
                fall_timeout = 16'($urandom_range(0, 6));
                fall_margin  = 32'($urandom_range(0, 60));
                threshold    = {32'($urandom_range(80, 160)), 32'($urandom_range(80, 160))};
            end
            for (int c = 0; c < 2; c++) begin
                data_in[c*32 +: 32] = 32'($urandom_range(0, 255));
                data_valid[c] = ($urandom_range(0, 3) != 0);
                rearm[c]      = ($urandom_range(0, 39) == 0);
                ch_enable[c]  = ($urandom_range(0, 59) != 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mode_ac_edge_detector_mc.md
MODE_AC_EDGE_DETECTOR_MC -- requirements
Module: mode_ac_edge_detector_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sample and threshold width, unsigned.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent detector channels.
REQ-003 SHALL have parameter RCW, default 4: run-length configuration width.
REQ-004 SHALL have parameter TCW, default 16: hold, final and timeout timer width.
REQ-005 SHALL have parameter PWW, default 16: pulse-width counter width.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port data_valid  in  NUM_CH  per-channel sample strobe.
REQ-009 SHALL have port data_in  in  NUM_CH*WIDTH  per-channel sample; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port threshold  in  NUM_CH*WIDTH  per-channel rise threshold.
REQ-011 SHALL have port run_needed  in  RCW  rising samples required for a rise; 0 and 1 both mean 1.
REQ-012 SHALL have ports hold_time, final_time, fall_timeout  in  TCW each  (fall_timeout of 0 disables the timeout).
REQ-013 SHALL have port fall_margin  in  WIDTH  hysteresis subtracted from the rise sample.
REQ-014 SHALL have ports ch_enable and rearm  in  NUM_CH each.
REQ-015 SHALL have ports rise_edge, fall_edge, timeout, pw_valid, busy  out  NUM_CH each.
REQ-016 SHALL have port pulse_width  out  NUM_CH*PWW.

Function
REQ-017 Each channel SHALL run an independent FSM: IDLE, COUNTING, HOLD, FALL, END.
REQ-018 FSM, counters and prev_val SHALL advance only on cycles with the channel's data_valid high; prev_val SHALL take data_in on every valid sample.
REQ-019 IDLE: on data_in >= threshold and data_in > prev_val, go to COUNTING with run=1; if run_needed <= 1, assert the rise and go directly to HOLD.
REQ-020 COUNTING: on data_in > prev_val, either increment run or, if run == run_needed-1, assert the rise; on data_in <= prev_val, go to IDLE with run cleared.
REQ-021 On a rise, the channel SHALL latch fall_thr = data_in - fall_margin, saturating at 0; load the hold timer with hold_time; clear the pulse-width counter; go to HOLD.
REQ-022 HOLD: timer 0 goes to FALL, else decrement, so HOLD lasts hold_time+1 samples; on entry to FALL, load the timeout timer with fall_timeout.
REQ-023 FALL: on data_in <= fall_thr, pulse fall_edge and pw_valid, present the pulse width, load final_time, go to END.
REQ-024 FALL: if the timeout is enabled and this is the fall_timeout-th FALL sample without a fall, pulse timeout, leave pw_valid low, load final_time, go to END.
REQ-025 A fall and a timeout on the same sample SHALL resolve as a fall.
REQ-026 END: timer 0 goes to IDLE, else decrement.
REQ-027 Pulse width SHALL count the valid samples after the rise sample, up to and including the fall sample, saturating at all-ones.
REQ-028 pulse_width SHALL hold its value until the next pw_valid.
REQ-029 rise_edge, fall_edge, timeout and pw_valid SHALL be registered, asserted the cycle after the qualifying sample edge, and exactly one clk cycle wide.
REQ-030 busy SHALL be high in HOLD, FALL and END.
REQ-031 hold_time, final_time and fall_timeout SHALL be sampled at timer load; threshold SHALL be read live in IDLE; run_needed SHALL be read live.
REQ-032 rearm[k] SHALL synchronously force channel k to IDLE, clear its counters, prev_val, fall_thr and pulse outputs (pulse_width retained), and SHALL take priority over data_valid.
REQ-033 ch_enable[k] low SHALL behave as rearm[k] held high.
REQ-034 Channels SHALL never interact.

Reset
REQ-035 rst_n low SHALL asynchronously set all states to IDLE; all counters, prev_val, fall_thr and pulse_width to 0; all outputs to 0.
REQ-036 Release of rst_n SHALL be synchronised to clk; the first valid sample after release SHALL be treated as an IDLE sample with prev_val=0.

Structure
REQ-037 A shared package mode_ac_pkg SHALL hold the state encoding (3-bit, IDLE=0 through END=4) and the default widths.
REQ-038 The per-channel logic SHALL be one sub-module, mode_ac_edge_channel, instantiated NUM_CH times by generate.
REQ-039 The top level SHALL contain only slicing, generate and the reset synchroniser.

Verification
REQ-040 Setup: threshold=100, run_needed=3. Stimulus: samples 50,120,130,140. Required: one-cycle rise_edge after 140 and busy=1.
REQ-041 Setup: run_needed=3. Stimulus: samples 120,130,125,126. Required: no rise, and the channel is in COUNTING with run=1 after 126.
REQ-042 Setup: margin=20, hold_time=2, rise at 140. Stimulus: samples 150,150,150,150,121,120. Required: fall_edge and pw_valid on 120, pulse_width=6.
REQ-043 Setup: fall_timeout=4, data held at 200 after HOLD. Stimulus: continue samples. Required: timeout after the 4th FALL sample, no fall_edge, and IDLE after final_time+1 END samples.
REQ-044 Stimulus: rearm[1] while ch1 is in FALL and ch0 is in HOLD. Required: ch1 is IDLE next cycle and ch0 is unaffected.
REQ-045 Stimulus: rst_n low mid-cycle. Required: all outputs 0 without a clock edge.
REQ-046 Setup: margin=500, rise at 140. Required: fall_thr=0, and a fall only on sample 0.
